pend_enc32to5: RTL and testbench

Sequential 32-to-5 encoder, the inverse of the register-file address decoder. It accepts a 32-bit request vector, such as pending interrupt lines or a register-write mask, and emits the 5-bit index of every set bit, lowest index first, one per accepted output handshake. It sits between multi-source request logic and any consumer that takes a single 5-bit address (register file, cause register, arbiter).

---
 rtl/enc_pkg.sv | 12 +
 rtl/lsb_enc32to5.sv | 28 ++
 rtl/pend_enc32to5.sv | 90 +++++++++
 tb/tb_pend_enc32to5.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared parameters and state type for the 32-to-5 pending-bit encoder.
package enc_pkg;

    localparam int N  = 32;
    localparam int AW = 5;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } enc_state_t;

endpackage

// File: rtl/lsb_enc32to5.sv
// Combinational lowest-set-bit encoder: index of lowest 1, any-set flag,
// and exactly-one-set flag.
module lsb_enc32to5
    import enc_pkg::*;
(
    input  logic [N-1:0]  vec,
    output logic [AW-1:0] idx,
    output logic          any,
    output logic          single
);

    logic [N-1:0] vec_m1;

    // Scan from the top so the lowest set bit wins.
    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = i[AW-1:0];
            end
        end
    end

    assign vec_m1 = vec - N'(1);
    assign any    = |vec;
    assign single = any && ((vec & vec_m1) == '0);

endmodule

// File: rtl/pend_enc32to5.sv
// Sequential 32-to-5 encoder: accepts a request vector and emits the index
// of each set bit, lowest first, one per output handshake.
module pend_enc32to5
    import enc_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_vec,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] adr,
    output logic [AW-1:0] seq,
    output logic          last,
    output logic          zero_drop
);

    enc_state_t    state_q, state_d;
    logic [N-1:0]  pend_q, pend_d;
    logic [AW-1:0] seq_q, seq_d;
    logic          zdrop_q, zdrop_d;

    logic [AW-1:0] low_idx;
    logic          low_any;
    logic          low_single;

    lsb_enc32to5 u_lsb (
        .vec    (pend_q),
        .idx    (low_idx),
        .any    (low_any),
        .single (low_single)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pend_q  <= '0;
            seq_q   <= '0;
            zdrop_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            seq_q   <= seq_d;
            zdrop_q <= zdrop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        seq_d   = seq_q;
        zdrop_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != '0) begin
                        pend_d  = in_vec;
                        seq_d   = '0;
                        state_d = EMIT;
                    end else begin
                        zdrop_d = 1'b1;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    if (low_single) begin
                        pend_d  = '0;
                        seq_d   = '0;
                        state_d = IDLE;
                    end else begin
                        pend_d = pend_q & ~(N'(1) << low_idx);
                        seq_d  = seq_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registered state; adr is gated to 0 when idle.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == EMIT);
    assign adr       = out_valid ? low_idx : '0;
    assign seq       = out_valid ? seq_q : '0;
    assign last      = out_valid && low_any && low_single;
    assign zero_drop = zdrop_q;

endmodule

// File: tb/tb_pend_enc32to5.sv
// Self-checking bench for pend_enc32to5: directed and random vectors
// against a bit-scan reference queue.
module tb_pend_enc32to5;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_vec;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  adr;
    logic [4:0]  seq;
    logic        last;
    logic        zero_drop;

    int tests;
    int fails;

    pend_enc32to5 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .adr       (adr),
        .seq       (seq),
        .last      (last),
        .zero_drop (zero_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".in_ready"},  {31'b0, in_ready},  32'd1);
        chk({tag, ".out_valid"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".adr"},       {27'b0, adr},       32'd0);
        chk({tag, ".seq"},       {27'b0, seq},       32'd0);
        chk({tag, ".last"},      {31'b0, last},      32'd0);
    endtask

    // mode 0: ready always high; 1: random ready; 2: low for 3 cycles first
    task automatic run_vec(input logic [31:0] v, input int mode,
                           input string tag);
        int q[$];
        int k;
        int cyc;
        int held;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) q.push_back(i);
        end
        chk({tag, ".accept_rdy"}, {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_vec   = v;
        tick();
        in_valid = 1'b0;
        if (q.size() == 0) begin
            chk({tag, ".zdrop"},   {31'b0, zero_drop}, 32'd1);
            chk({tag, ".zdrop_ov"}, {31'b0, out_valid}, 32'd0);
            chk({tag, ".zdrop_ir"}, {31'b0, in_ready},  32'd1);
            tick();
            chk({tag, ".zdrop_end"}, {31'b0, zero_drop}, 32'd0);
            chk_idle({tag, ".after_zero"});
            return;
        end
        k    = 0;
        cyc  = 0;
        held = 0;
        while (k < q.size()) begin
            if (cyc > 400) begin
                chk({tag, ".timeout"}, 32'd1, 32'd0);
                break;
            end
            chk({tag, ".ov"},   {31'b0, out_valid}, 32'd1);
            chk({tag, ".ir"},   {31'b0, in_ready},  32'd0);
            chk({tag, ".zd"},   {31'b0, zero_drop}, 32'd0);
            chk({tag, ".adr"},  {27'b0, adr},       q[k]);
            chk({tag, ".seq"},  {27'b0, seq},       k);
            chk({tag, ".last"}, {31'b0, last},
                (k == q.size() - 1) ? 32'd1 : 32'd0);
            case (mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = (held >= 3);
                default: out_ready = 1'b1;
            endcase
            held++;
            in_valid = 1'($urandom_range(0, 1));
            in_vec   = $urandom;
            tick();
            if (out_ready) k++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk_idle({tag, ".done"});
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_vec    = '0;
        out_ready = 1'b0;
        #12;
        chk_idle("reset");
        chk("reset.zdrop", {31'b0, zero_drop}, 32'd0);
        rst_n = 1'b1;
        tick();

        run_vec(32'h0000_0001, 0, "one");
        run_vec(32'h8000_0011, 0, "three");
        run_vec(32'hFFFF_FFFF, 0, "all");
        run_vec(32'h0000_0300, 2, "hold");
        run_vec(32'h0000_0000, 0, "zero");
        run_vec(32'h8000_0000, 1, "top");

        for (int r = 0; r < 12; r++) begin
            logic [31:0] v;
            v = $urandom;
            if (r % 3 == 1) v = v & $urandom & $urandom;
            if (r % 4 == 3) v = '0;
            run_vec(v, 1, "rand");
        end

        // Asynchronous reset in the middle of EMIT.
        in_valid = 1'b1;
        in_vec   = 32'h0000_F000;
        tick();
        in_valid = 1'b0;
        chk("rst.adr12", {27'b0, adr}, 32'd12);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("rst.adr13", {27'b0, adr}, 32'd13);
        chk("rst.seq1",  {27'b0, seq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst.async");
        chk("rst.zdrop", {31'b0, zero_drop}, 32'd0);
        tick();
        chk_idle("rst.held");
        rst_n = 1'b1;
        tick();
        run_vec(32'h0000_0004, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
